// File: rtl/stepper_enc_ctrl.sv
// stepper_enc_ctrl
// Single-axis quadrature encoder decoder with a step/dir pulse generator.
//   - enc_a/enc_b are synchronised and decoded at 4x resolution into a signed,
//     wrapping position counter. An illegal transition (both channels changing
//     in one sample) sets a sticky error flag.
//   - sw_dir is synchronised and debounced. Each accepted press toggles the
//     requested direction.
//   - A step FSM (IDLE/SETUP/HIGH/LOW) produces STEP_HI-cycle step pulses.
//     The period is programmable, and dir has a setup time before the next
//     step edge.
// Optional build macro: ENC_FILT_EN adds a FILT_LEN-deep glitch filter on each
// synchronised encoder channel.
// Ports:
//   CLK, RSTN        clock, asynchronous active-low reset
//   enc_a, enc_b     encoder channels (asynchronous)
//   sw_dir           direction push-switch (asynchronous, bouncy)
//   run              enable step generation
//   step_period      step period in CLK cycles (latched per pulse)
//   clr_err          single-cycle pulse that clears enc_err
//   step, dir, mo    driver interface (mo is the static MODE)
//   idir             direction of the last encoder count, 1 = up
//   pos, LPORT       encoder position and its low LED_W bits
//   enc_err          sticky illegal-transition flag
module stepper_enc_ctrl #(
  parameter int         POS_W     = 16,
  parameter int         LED_W     = 8,
  parameter int         PER_W     = 16,
  parameter int         STEP_HI   = 4,
  parameter int         DIR_SETUP = 8,
  parameter int         DEB_CYC   = 1000,
  parameter logic [1:0] MODE      = 2'b11,
  parameter int         FILT_LEN  = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             sw_dir,
  input  logic             run,
  input  logic [PER_W-1:0] step_period,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic [1:0]       mo,
  output logic             idir,
  output logic [POS_W-1:0] pos,
  output logic [LED_W-1:0] LPORT,
  output logic             enc_err
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  // One counter covers SETUP and the HIGH+LOW span, so it must hold the larger
  // of the two ranges.
  localparam int SET_W = $clog2(DIR_SETUP + STEP_HI + 2);
  localparam int CNT_W = (PER_W > SET_W) ? PER_W : SET_W;
  localparam int DCW   = $clog2(DEB_CYC + 1);

  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(STEP_HI + 1);
  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(STEP_HI - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYC - 1);

  // Position of an AB code along the forward Gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  logic [1:0] a_sync, b_sync, sw_sync;
  logic [1:0] ab_cur, ab_prev, mv;

  assign mo    = MODE;
  assign LPORT = pos[LED_W-1:0];

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_sync  <= 2'b00;
      b_sync  <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      a_sync  <= {a_sync[0], enc_a};
      b_sync  <= {b_sync[0], enc_b};
      sw_sync <= {sw_sync[0], sw_dir};
    end
  end

`ifdef ENC_FILT_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILT_LEN - 1);
  logic [FCW-1:0] a_cnt, b_cnt;
  logic           a_flt, b_flt;

  // Glitch filter: a channel changes only after FILT_LEN consecutive differing samples.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_cnt <= {FCW{1'b0}};
      b_cnt <= {FCW{1'b0}};
      a_flt <= 1'b0;
      b_flt <= 1'b0;
    end else begin
      if (a_sync[1] == a_flt) begin
        a_cnt <= {FCW{1'b0}};
      end else if (a_cnt == FLT_LAST) begin
        a_flt <= a_sync[1];
        a_cnt <= {FCW{1'b0}};
      end else begin
        a_cnt <= a_cnt + FCW'(1);
      end
      if (b_sync[1] == b_flt) begin
        b_cnt <= {FCW{1'b0}};
      end else if (b_cnt == FLT_LAST) begin
        b_flt <= b_sync[1];
        b_cnt <= {FCW{1'b0}};
      end else begin
        b_cnt <= b_cnt + FCW'(1);
      end
    end
  end

  assign ab_cur = {a_flt, b_flt};
`else
  assign ab_cur = {a_sync[1], b_sync[1]};
`endif

  // Distance moved along the Gray sequence: 1 = forward, 3 = reverse, 2 = illegal.
  assign mv = gray_idx(ab_cur) - gray_idx(ab_prev);

  // Quadrature decode: position counter, count direction and sticky error.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ab_prev <= 2'b00;
      pos     <= {POS_W{1'b0}};
      idir    <= 1'b0;
      enc_err <= 1'b0;
    end else begin
      ab_prev <= ab_cur;
      case (mv)
        2'd1: begin
          pos  <= pos + POS_W'(1);
          idir <= 1'b1;
        end
        2'd3: begin
          pos  <= pos - POS_W'(1);
          idir <= 1'b0;
        end
        default: begin
          pos  <= pos;
          idir <= idir;
        end
      endcase
      // An illegal transition wins over a simultaneous clear.
      if (mv == 2'd2) begin
        enc_err <= 1'b1;
      end else if (clr_err) begin
        enc_err <= 1'b0;
      end else begin
        enc_err <= enc_err;
      end
    end
  end

  logic           sw_deb, dir_req;
  logic [DCW-1:0] deb_cnt;

  // Switch debounce. Each accepted press (0->1) toggles the requested direction.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sw_deb  <= 1'b0;
      dir_req <= 1'b0;
      deb_cnt <= {DCW{1'b0}};
    end else if (sw_sync[1] == sw_deb) begin
      deb_cnt <= {DCW{1'b0}};
    end else if (deb_cnt == DEB_LAST) begin
      sw_deb  <= sw_sync[1];
      deb_cnt <= {DCW{1'b0}};
      if (sw_sync[1]) begin
        dir_req <= ~dir_req;
      end
    end else begin
      deb_cnt <= deb_cnt + DCW'(1);
    end
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, per_lat, per_nxt, per_eff;
  logic             dir_nxt, launch;

  assign per_eff = (CNT_W'(step_period) < MIN_PER) ? MIN_PER : CNT_W'(step_period);

  // Step FSM next state. cnt runs from the step rising edge, so HIGH+LOW spans exactly per_lat cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (run) begin
          launch = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (cnt == SET_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          state_nxt = SETUP;
        end
      end
      HIGH: begin
        if (cnt == HI_LAST) begin
          state_nxt = LOW;
        end else begin
          state_nxt = HIGH;
        end
      end
      LOW: begin
        if (cnt == per_lat - CNT_ONE) begin
          if (run) begin
            launch = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = LOW;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Start of a new pulse: latch the period, and go through SETUP if dir must change.
    if (launch) begin
      per_nxt = per_eff;
      cnt_nxt = {CNT_W{1'b0}};
      if (dir_req != dir) begin
        dir_nxt   = dir_req;
        state_nxt = SETUP;
      end else begin
        dir_nxt   = dir;
        state_nxt = HIGH;
      end
    end else begin
      per_nxt = per_lat;
      dir_nxt = dir;
    end
  end

  // Step FSM state register. step is registered from the next state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      cnt     <= {CNT_W{1'b0}};
      per_lat <= MIN_PER;
      dir     <= 1'b0;
      step    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      per_lat <= per_nxt;
      dir     <= dir_nxt;
      step    <= (state_nxt == HIGH);
    end
  end

endmodule

// File: tb/tb_stepper_enc_ctrl.sv
// Self-checking bench for stepper_enc_ctrl (default parameters, filter disabled).
module tb_stepper_enc_ctrl;
  localparam int STEP_HI   = 4;
  localparam int DIR_SETUP = 8;

  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        enc_a = 1'b0, enc_b = 1'b0, sw_dir = 1'b0, run = 1'b0, clr_err = 1'b0;
  logic [15:0] step_period = 16'd0;
  logic        step, dir, idir, enc_err;
  logic [1:0]  mo;
  logic [15:0] pos;
  logic [7:0]  LPORT;

  stepper_enc_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .enc_a(enc_a), .enc_b(enc_b), .sw_dir(sw_dir),
    .run(run), .step_period(step_period), .clr_err(clr_err),
    .step(step), .dir(dir), .mo(mo), .idir(idir), .pos(pos), .LPORT(LPORT),
    .enc_err(enc_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: cycle stamps of step rises, pulse widths and dir changes.
  int   cyc = 0;
  logic step_q = 1'b0, dir_q = 1'b0;
  int   last_rise = 0;
  int   rise_q[$], width_q[$], dchg_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (step && !step_q) begin
      rise_q.push_back(cyc);
      last_rise <= cyc;
    end
    if (!step && step_q) width_q.push_back(cyc - last_rise);
    if (dir !== dir_q) dchg_q.push_back(cyc);
    step_q <= step;
    dir_q  <= dir;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [1:0] ab_of(input int ph);
    logic [1:0] t [4];
    t = '{2'b00, 2'b01, 2'b11, 2'b10};
    return t[ph % 4];
  endfunction

  task automatic drive_ab(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick(3);
    RSTN = 1'b1;
    tick(2);
  endtask

  task automatic wait_rises(input int n, input int max_cyc);
    int k = 0;
    while (rise_q.size() < n && k < max_cyc) begin
      tick(1);
      k++;
    end
    chk("rise_wait", 32'(rise_q.size() >= n), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  ab;
    logic        clr;
    logic [15:0] pos;
    logic        idir;
    logic        err;
  } vec_t;

  vec_t        vecs [10];
  int          ph;
  logic [15:0] pm;
  logic        im, em;
  int          per_tab [5];
  int          exp_per, r, k, found;

  initial begin
    vecs[0] = '{2'b10, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{2'b11, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[8] = '{2'b10, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{2'b00, 1'b0, 16'h0000, 1'b1, 1'b0};

    // Reset values while RSTN is held low.
    tick(3);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_idir", 32'(idir), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_lport", 32'(LPORT), 32'd0);
    chk("rst_err", 32'(enc_err), 32'd0);
    chk("rst_mo", 32'(mo), 32'd3);
    RSTN = 1'b1;
    tick(2);

    // Table-driven decode vectors, starting from AB=00 and pos=0.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] ep;
      drive_ab(vecs[i].ab);
      if (vecs[i].clr) begin
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
      end
      tick(6);
      ep = vecs[i].pos;
      chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(ep));
      chk($sformatf("vec%0d_lport", i), 32'(LPORT), 32'(ep[7:0]));
      chk($sformatf("vec%0d_idir", i), 32'(idir), 32'(vecs[i].idir));
      chk($sformatf("vec%0d_err", i), 32'(enc_err), 32'(vecs[i].err));
    end

    // Four full forward cycles, 10 CLK per edge.
    do_reset();
    ph = 0;
    for (int i = 0; i < 16; i++) begin
      ph = ph + 1;
      drive_ab(ab_of(ph));
      tick(10);
    end
    chk("fwd16_pos", 32'(pos), 32'd16);
    chk("fwd16_lport", 32'(LPORT), 32'h10);
    chk("fwd16_idir", 32'(idir), 32'd1);
    chk("fwd16_err", 32'(enc_err), 32'd0);

    // Pin-to-pos latency of 3 CLK.
    ph = ph + 1;
    drive_ab(ab_of(ph));
    tick(2);
    chk("lat_early", 32'(pos), 32'd16);
    tick(1);
    chk("lat_3clk", 32'(pos), 32'd17);

    // Illegal transition in the same cycle as clr_err keeps the error set.
    ph = ph + 2;
    drive_ab(ab_of(ph));
    tick(2);
    chk("ill_early", 32'(enc_err), 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_vs_illegal", 32'(enc_err), 32'd1);
    chk("ill_pos_hold", 32'(pos), 32'd17);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    chk("clr_err", 32'(enc_err), 32'd0);

    // Random encoder motion against a phase/position model.
    pm = 16'd17;
    im = 1'b1;
    em = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        ph = ph + 1; pm = pm + 16'd1; im = 1'b1;
        drive_ab(ab_of(ph));
      end else if (r < 8) begin
        ph = ph + 3; pm = pm - 16'd1; im = 1'b0;
        drive_ab(ab_of(ph));
      end else if (r == 8) begin
        ph = ph + 2; em = 1'b1;
        drive_ab(ab_of(ph));
      end else begin
        em = 1'b0;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
      end
      tick(6);
      chk("rnd_pos", 32'(pos), 32'(pm));
      chk("rnd_lport", 32'(LPORT), 32'(pm[7:0]));
      chk("rnd_idir", 32'(idir), 32'(im));
      chk("rnd_err", 32'(enc_err), 32'(em));
    end

    // Step period sweep. The effective period is max(period, STEP_HI+1).
    per_tab = '{20, 2, 0, 7, int'($urandom_range(1, 30))};
    run = 1'b1;
    for (int p = 0; p < 5; p++) begin
      step_period = 16'(per_tab[p]);
      exp_per = (per_tab[p] < STEP_HI + 1) ? STEP_HI + 1 : per_tab[p];
      rise_q.delete();
      wait_rises(2, 200);
      rise_q.delete();
      width_q.delete();
      wait_rises(4, exp_per * 6 + 50);
      for (int j = 1; j < 4 && j < rise_q.size(); j++)
        chk($sformatf("period_%0d", per_tab[p]), 32'(rise_q[j] - rise_q[j-1]), 32'(exp_per));
      for (int j = 0; j < 3 && j < width_q.size(); j++)
        chk($sformatf("width_%0d", per_tab[p]), 32'(width_q[j]), 32'(STEP_HI));
    end

    // Bouncy switch: only the final stable press is accepted.
    step_period = 16'd20;
    tick(40);
    dchg_q.delete();
    rise_q.delete();
    for (int i = 0; i < 5; i++) begin
      sw_dir = 1'b1;
      tick(150);
      sw_dir = 1'b0;
      tick(60);
    end
    chk("bounce_no_dir", 32'(dchg_q.size()), 32'd0);
    sw_dir = 1'b1;
    tick(1100);
    chk("press_dir_chg", 32'(dchg_q.size()), 32'd1);
    chk("press_dir", 32'(dir), 32'd1);
    found = -1;
    if (dchg_q.size() > 0) begin
      foreach (rise_q[j])
        if (found < 0 && rise_q[j] > dchg_q[0]) found = rise_q[j] - dchg_q[0];
    end
    chk("dir_setup", 32'(found), 32'(DIR_SETUP));
    sw_dir = 1'b0;
    tick(1100);
    chk("release_no_toggle", 32'(dchg_q.size()), 32'd1);

    // run dropped early in a pulse: the pulse completes, then no more steps.
    k = 0;
    while (step && k < 50) begin tick(1); k++; end
    rise_q.delete();
    width_q.delete();
    k = 0;
    while (rise_q.size() < 1 && k < 100) begin tick(1); k++; end
    run = 1'b0;
    tick(60);
    chk("drop_rises", 32'(rise_q.size()), 32'd1);
    chk("drop_width", (width_q.size() > 0) ? 32'(width_q[0]) : 32'hFFFF_FFFF, 32'(STEP_HI));
    chk("drop_step_low", 32'(step), 32'd0);

    // Asynchronous reset in the middle of LOW.
    ph = ph + 2;
    drive_ab(ab_of(ph));
    tick(6);
    chk("pre_rst_err", 32'(enc_err), 32'd1);
    run = 1'b1;
    width_q.delete();
    k = 0;
    while (width_q.size() < 1 && k < 100) begin tick(1); k++; end
    tick(2);
    chk("pre_rst_dir", 32'(dir), 32'd1);
    #3;
    RSTN = 1'b0;
    #1;
    chk("async_step", 32'(step), 32'd0);
    chk("async_dir", 32'(dir), 32'd0);
    chk("async_idir", 32'(idir), 32'd0);
    chk("async_pos", 32'(pos), 32'd0);
    chk("async_lport", 32'(LPORT), 32'd0);
    chk("async_err", 32'(enc_err), 32'd0);
    chk("async_mo", 32'(mo), 32'd3);
    run = 1'b0;
    tick(2);
    RSTN = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_enc_ctrl.md
Name: stepper_enc_ctrl

Overview:
Parametrised successor of the single-axis LED encoder/stepper block. Decodes a quadrature encoder into a signed wrapping position counter with 4x resolution and illegal-transition detection, mirrors position on LEDs, and generates timed step/dir pulses for the stepper driver at a programmable rate. The direction switch is debounced, and direction changes honour a setup time before the next step. Sits between board I/O (encoder, switch, LEDs) and the external driver chip.

Parameters:
POS_W, 16, position counter width (bits)
LED_W, 8, LED port width, LED_W <= POS_W
PER_W, 16, step period field width
STEP_HI, 4, step high time in CLK cycles (>=1)
DIR_SETUP, 8, cycles dir must be stable before a step rising edge (>=1)
DEB_CYC, 1000, cycles sw_dir must be stable to be accepted
MODE, 2'b11, static microstep code driven on mo (11 = 1/16)
FILT_LEN, 3, glitch filter depth (only with ENC_FILT_EN)

Ports:
CLK  in  1  system clock
RSTN  in  1  asynchronous active-low reset
enc_a  in  1  encoder channel A, asynchronous
enc_b  in  1  encoder channel B, asynchronous
sw_dir  in  1  direction push-switch, asynchronous, bouncy
run  in  1  enable step generation
step_period  in  PER_W  step period in CLK cycles
clr_err  in  1  single-cycle pulse, clears enc_err
step  out  1  step pulse to driver
dir  out  1  direction to driver
mo  out  2  microstep mode to driver
idir  out  1  direction of last encoder count, 1 = up
pos  out  POS_W  encoder position
LPORT  out  LED_W  pos[LED_W-1:0]
enc_err  out  1  sticky illegal-transition flag

Behaviour:
- Reset (RSTN low, async): step=0, dir=0, idir=0, pos=0, LPORT=0, enc_err=0, FSM=IDLE, debounced switch=0, synchronisers=0; mo=MODE always.
- enc_a, enc_b, sw_dir pass 2-flop synchronisers; decode uses the synchronised AB and its previous sample.
- Forward sequence AB 00->01->11->10->00: pos+1, idir=1. Reverse: pos-1, idir=0. No change: hold.
- Both bits changing in one sample: illegal; pos and idir hold, enc_err=1.
- enc_err sticky until clr_err; illegal transition in the same cycle as clr_err leaves enc_err=1.
- pos wraps modulo 2^POS_W (max+1 -> 0, 0-1 -> all ones). pos/LPORT update one cycle after the synchronised edge (3 CLK from pin).
- Debounce: synchronised sw_dir must hold a value for DEB_CYC consecutive cycles to be accepted; each accepted 0->1 toggles internal dir_req.
- Step FSM states IDLE, SETUP, HIGH, LOW:
  - IDLE: step=0. If run: dir_req!=dir -> dir=dir_req, SETUP; else -> HIGH. Latch period on leaving IDLE.
  - SETUP: step=0, DIR_SETUP cycles, then HIGH.
  - HIGH: step=1 for STEP_HI cycles, then LOW.
  - LOW: step=0 until latched period elapses (rising edge to rising edge = period cycles, excluding SETUP); then run -> same decision as IDLE, else IDLE.
- Effective period = max(step_period, STEP_HI+1); step_period=0 gives STEP_HI+1.
- dir changes only on the IDLE/LOW->SETUP transition, never during HIGH.
- run deasserted mid-pulse: HIGH and LOW complete, no truncated pulse; then IDLE.
- step_period changes mid-pulse take effect at the next latch.

Optional Feature:
ENC_FILT_EN: defined -> each synchronised encoder channel is accepted only after FILT_LEN consecutive equal samples (adds FILT_LEN cycles latency); pulses shorter than FILT_LEN cycles are ignored. Undefined -> no filter, decode directly from the synchronisers.

Test Plan:
- Reset then 4 forward quadrature cycles (16 edges, 10 CLK apart) -> pos=16, LPORT=8'h10, idir=1, enc_err=0.
- From pos=0 apply 1 reverse edge -> pos=16'hFFFF, LPORT=8'hFF, idir=0.
- AB 00->11 in one step -> pos unchanged, enc_err=1; clr_err pulse -> enc_err=0.
- run=1, step_period=20 -> step high 4 cycles, rising edges every 20 cycles; step_period=2 -> period 5.
- sw_dir bounces 5x shorter than DEB_CYC then holds high -> one toggle; dir changes, next step rising edge exactly DIR_SETUP cycles after dir change.
- run dropped 1 cycle into HIGH -> full 4-cycle pulse, then step stays 0; RSTN low mid-LOW -> all outputs at reset values immediately.
